// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ valid/ready requesters,
// granting bursts of up to BURST beats and stalling (never releasing) on fifo_full.
module fifo_wr_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned DSIZE = 8,
  parameter int unsigned BURST = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NREQ-1:0]       req_valid_i,
  input  logic [NREQ*DSIZE-1:0] req_data_i,
  input  logic [NREQ-1:0]       req_last_i,
  output logic [NREQ-1:0]       req_ready_o,
  input  logic                  fifo_full_i,
  output logic                  fifo_wr_en_o,
  output logic [DSIZE-1:0]      fifo_din_o,
  output logic [NREQ-1:0]       grant_o,
  output logic                  busy_o
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned BW = (BURST > 0) ? $clog2(BURST + 1) : 1;

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [IW-1:0]   last_q, last_d;
  logic [BW-1:0]   beat_q, beat_d;

  logic            in_grant;
  logic            xfer;
  logic [IW-1:0]   win;
  logic            found;

  // First valid requester scanning upward from last_q+1, wrapping at NREQ.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      int idx;
      idx = (int'(last_q) + k) % int'(NREQ);
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  // Reset gates the handshake combinationally so an aborted beat is never written.
  assign in_grant     = (state_q == StGrant) && rst_ni;
  assign xfer         = in_grant && req_valid_i[gidx_q] && !fifo_full_i;
  assign fifo_wr_en_o = xfer;
  assign req_ready_o  = (in_grant && !fifo_full_i) ? grant_q : '0;
  assign fifo_din_o   = in_grant ? req_data_i[int'(gidx_q)*DSIZE +: DSIZE] : '0;
  assign grant_o      = grant_q;
  assign busy_o       = (state_q == StGrant);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    beat_d  = beat_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StGrant;
          gidx_d  = win;
          grant_d = NREQ'(1) << win;
          beat_d  = '0;
        end
      end
      StGrant: begin
        if (!req_valid_i[gidx_q] ||
            (xfer && (req_last_i[gidx_q] || beat_q == BW'(BURST - 1)))) begin
          state_d = StIdle;
          last_d  = gidx_q;
          grant_d = '0;
          beat_d  = '0;
        end else if (xfer) begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IW'(NREQ - 1);
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a BURST=4 instance and a BURST=1 instance on shared inputs.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  valid;
  logic [31:0] data;
  logic [3:0]  last;
  logic        full;

  logic [3:0]  ready, grant, ready1, grant1;
  logic        wr, busy, wr1, busy1;
  logic [7:0]  din, din1;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NREQ(4), .DSIZE(8), .BURST(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(valid), .req_data_i(data),
    .req_last_i(last), .req_ready_o(ready), .fifo_full_i(full),
    .fifo_wr_en_o(wr), .fifo_din_o(din), .grant_o(grant), .busy_o(busy)
  );

  fifo_wr_arbiter #(.NREQ(4), .DSIZE(8), .BURST(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(valid), .req_data_i(data),
    .req_last_i(last), .req_ready_o(ready1), .fifo_full_i(full),
    .fifo_wr_en_o(wr1), .fifo_din_o(din1), .grant_o(grant1), .busy_o(busy1)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid = '0;
    data  = '0;
    last  = '0;
    full  = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_chk++; if (grant !== 4'b0) $display("FAIL reset grant: got %b want 0000", grant); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset busy: got %b want 0", busy); else n_pass++;
    n_chk++; if (ready !== 4'b0) $display("FAIL reset ready: got %b want 0000", ready); else n_pass++;
    n_chk++; if (wr !== 1'b0) $display("FAIL reset wr_en: got %b want 0", wr); else n_pass++;
    n_chk++; if (din !== 8'h00) $display("FAIL reset din: got %h want 00", din); else n_pass++;
  endtask

  // Requester 0 alone, no last: 4-beat burst, bubble, regrant, then drop.
  task automatic test_single();
    logic [7:0] dv [8] = '{8'h10, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h14, 8'h15};
    logic       ew [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      cyc();
      valid = 4'b0001;
      data  = {24'h0, dv[c]};
      #1;
      n_chk++; if (wr !== ew[c]) $display("FAIL single wr c%0d: got %b want %b", c, wr, ew[c]); else n_pass++;
      n_chk++; if (grant !== {3'b0, ew[c]}) $display("FAIL single grant c%0d: got %b want %b", c, grant, {3'b0, ew[c]}); else n_pass++;
      if (ew[c]) begin
        n_chk++; if (din !== dv[c]) $display("FAIL single din c%0d: got %h want %h", c, din, dv[c]); else n_pass++;
      end
    end
    cyc();
    valid = '0;
    #1;
    n_chk++; if (busy !== 1'b1 || wr !== 1'b0) $display("FAIL single drop c8: got busy=%b wr=%b want busy=1 wr=0", busy, wr); else n_pass++;
    cyc();
    #1;
    n_chk++; if (busy !== 1'b0) $display("FAIL single drop c9 busy: got %b want 0", busy); else n_pass++;
  endtask

  // All four valid, 2-beat bursts with last on beat 2: grants 0,1,2,3,0 and wr 0,1,1 repeating.
  task automatic test_round_robin();
    logic [3:0] b;
    int g, ph;
    logic ew;
    logic [3:0] eg;
    logic [7:0] ed;
    do_reset();
    b = '0;
    for (int c = 0; c < 15; c++) begin
      cyc();
      valid = 4'b1111;
      for (int r = 0; r < 4; r++) data[r*8 +: 8] = 8'(r * 16) + {7'b0, b[r]};
      last = b;
      ph = c % 3;
      g  = (c / 3) % 4;
      ew = (ph != 0);
      eg = ew ? (4'b0001 << g) : 4'b0000;
      ed = 8'(g * 16 + ph - 1);
      #1;
      n_chk++; if (wr !== ew) $display("FAIL rr wr c%0d: got %b want %b", c, wr, ew); else n_pass++;
      n_chk++; if (grant !== eg) $display("FAIL rr grant c%0d: got %b want %b", c, grant, eg); else n_pass++;
      if (ew) begin
        n_chk++; if (din !== ed) $display("FAIL rr din c%0d: got %h want %h", c, din, ed); else n_pass++;
        n_chk++; if (ready !== eg) $display("FAIL rr ready c%0d: got %b want %b", c, ready, eg); else n_pass++;
        b[g] = ~b[g];
      end
    end
  endtask

  // Requester 1 stalled by full for 3 cycles after beat 2; burst resumes and ends at beat 4.
  task automatic test_full_stall();
    logic [7:0] dv [9] = '{8'h20, 8'h20, 8'h21, 8'h22, 8'h22, 8'h22, 8'h22, 8'h23, 8'h24};
    logic       fv [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       ew [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [3:0] eg [9] = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0};
    logic [3:0] er;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      cyc();
      valid = 4'b0010;
      data  = {16'h0, dv[c], 8'h0};
      full  = fv[c];
      er    = ew[c] ? 4'b0010 : 4'b0000;
      #1;
      n_chk++; if (wr !== ew[c]) $display("FAIL stall wr c%0d: got %b want %b", c, wr, ew[c]); else n_pass++;
      n_chk++; if (grant !== eg[c]) $display("FAIL stall grant c%0d: got %b want %b", c, grant, eg[c]); else n_pass++;
      n_chk++; if (ready !== er) $display("FAIL stall ready c%0d: got %b want %b", c, ready, er); else n_pass++;
      if (ew[c]) begin
        n_chk++; if (din !== dv[c]) $display("FAIL stall din c%0d: got %h want %h", c, din, dv[c]); else n_pass++;
      end
    end
  endtask

  // Requester 2 drops after one beat; next winner is 3 when valid, otherwise wraps to 0.
  task automatic test_drop();
    do_reset();
    cyc(); valid = 4'b0100; data = 32'h0042_0000; #1;
    cyc(); #1;
    n_chk++; if (grant !== 4'b0100 || wr !== 1'b1) $display("FAIL drop first beat: got grant=%b wr=%b want 0100/1", grant, wr); else n_pass++;
    cyc(); valid = 4'b1000; #1;
    n_chk++; if (grant !== 4'b0100 || wr !== 1'b0 || ready !== 4'b0100) $display("FAIL drop release cycle: got grant=%b wr=%b ready=%b want 0100/0/0100", grant, wr, ready); else n_pass++;
    cyc(); #1;
    n_chk++; if (busy !== 1'b0) $display("FAIL drop idle busy: got %b want 0", busy); else n_pass++;
    cyc(); #1;
    n_chk++; if (grant !== 4'b1000) $display("FAIL drop next is 3: got %b want 1000", grant); else n_pass++;
    do_reset();
    cyc(); valid = 4'b0100; #1;
    cyc(); #1;
    cyc(); valid = 4'b0011; #1;
    cyc(); #1;
    cyc(); #1;
    n_chk++; if (grant !== 4'b0001) $display("FAIL drop next wraps to 0: got %b want 0001", grant); else n_pass++;
  endtask

  // One-cycle reset during beat 2 of requester 3 aborts the burst; arbitration restarts at 0.
  task automatic test_reset_mid_burst();
    do_reset();
    cyc(); valid = 4'b1000; data = 32'h3000_0000; #1;
    cyc(); #1;
    n_chk++; if (grant !== 4'b1000 || wr !== 1'b1 || din !== 8'h30) $display("FAIL rstmid beat1: got grant=%b wr=%b din=%h want 1000/1/30", grant, wr, din); else n_pass++;
    cyc(); data = 32'h3100_0000; rst_n = 1'b0; #1;
    n_chk++; if (wr !== 1'b0) $display("FAIL rstmid wr during reset: got %b want 0", wr); else n_pass++;
    n_chk++; if (ready !== 4'b0000) $display("FAIL rstmid ready during reset: got %b want 0000", ready); else n_pass++;
    cyc(); rst_n = 1'b1; valid = 4'b1001; #1;
    n_chk++; if (grant !== 4'b0000 || busy !== 1'b0) $display("FAIL rstmid after: got grant=%b busy=%b want 0000/0", grant, busy); else n_pass++;
    cyc(); #1;
    n_chk++; if (grant !== 4'b0001) $display("FAIL rstmid restart at 0: got %b want 0001", grant); else n_pass++;
  endtask

  // BURST=1 instance: one write per grant, order 0,1,2,0, a write every other cycle.
  task automatic test_burst1();
    logic [3:0] eg;
    logic       ew;
    int g;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      cyc();
      valid = 4'b0111;
      data  = 32'h0020_1000;
      ew = (c % 2) == 1;
      g  = ((c - 1) / 2) % 3;
      eg = ew ? (4'b0001 << g) : 4'b0000;
      #1;
      n_chk++; if (wr1 !== ew) $display("FAIL burst1 wr c%0d: got %b want %b", c, wr1, ew); else n_pass++;
      n_chk++; if (grant1 !== eg) $display("FAIL burst1 grant c%0d: got %b want %b", c, grant1, eg); else n_pass++;
      if (ew) begin
        n_chk++; if (din1 !== 8'(g * 16)) $display("FAIL burst1 din c%0d: got %h want %h", c, din1, 8'(g * 16)); else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_drop();
    test_reset_mid_burst();
    test_burst1();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares one synchronous FIFO write port among NREQ requesters. Each requester offers data on a valid/ready handshake. The arbiter grants one requester at a time for a burst of up to BURST beats and drives the FIFO's wr_en/din directly. It respects the FIFO full flag, so no beat is lost or duplicated. It sits immediately upstream of the FIFO write side.

## Interface
- NREQ, 4, number of requesters (≥2)
- DSIZE, 8, data width; must equal the FIFO DSIZE
- BURST, 4, maximum beats per grant (≥1)

- clk  in  1  single clock, all state on rising edge
- rstn  in  1  synchronous, active-low reset
- req_valid  in  NREQ  per-requester data valid
- req_data  in  NREQ*DSIZE  requester i data in bits [i*DSIZE +: DSIZE]
- req_last  in  NREQ  per-requester end-of-burst marker, sampled with a beat
- req_ready  out  NREQ  per-requester accept; at most one bit high
- fifo_full  in  1  FIFO full flag
- fifo_wr_en  out  1  FIFO write enable
- fifo_din  out  DSIZE  FIFO write data
- grant  out  NREQ  registered one-hot current grant; 0 when idle
- busy  out  1  high while in GRANT state

## Operation
- One clock; reset is synchronous and active-low (clk, rstn).
- Reset values:
  - state=IDLE, grant=0, beat count=0, last-grant pointer=NREQ-1, so requester 0 wins first.
  - Outputs: req_ready=0, fifo_wr_en=0, fifo_din=0, busy=0.
- States: IDLE, GRANT.
- **IDLE:**
  - If any req_valid is high, pick the first valid requester scanning from last_grant+1 upward, modulo NREQ.
  - Next cycle: grant=onehot(winner), beat=0, state=GRANT.
  - If no req_valid is high, stay in IDLE.
- **GRANT (requester g):**
  - req_ready[g] = !fifo_full. All other req_ready bits are 0.
  - Transfer = req_valid[g] & req_ready[g].
  - fifo_wr_en = transfer. fifo_din = req_data slice g, and 0 when not in GRANT.
  - Each transfer increments beat; beat is $clog2(BURST+1) bits wide and never wraps.
- **Release back to IDLE.** On the cycle after any of the following, the block returns to IDLE with last_grant=g, grant=0 and beat=0:
  - (a) a transfer with req_last[g]=1;
  - (b) a transfer that makes beat reach BURST;
  - (c) req_valid[g]=0 in a GRANT cycle, i.e. the requester went idle.
- fifo_full alone never releases the grant. The granted requester stalls, and no beat counts while full.
- Simultaneous conditions (a) and (b) produce a single release.
- Requester i≠g changing req_valid during GRANT has no effect until the next IDLE.
- rstn low forces req_ready=0 and fifo_wr_en=0 combinationally in that cycle. A burst in progress aborts; a beat presented during the reset cycle is not written.
- Data integrity: a FIFO write occurs exactly when a requester sees valid&ready. No write happens while fifo_full=1.

## Timing
- Arbitration latency: req_valid rising in IDLE at cycle n gives grant/busy at n+1. The first transfer is possible at n+1.
- Throughput inside a burst: 1 beat/cycle while not full.
- One IDLE bubble cycle between consecutive grants; the maximum sustained rate is BURST/(BURST+1).
- fifo_full is used combinationally in the same cycle. The FIFO's full must be a registered-pointer compare, with no path from wr_en back to full in the same cycle.
- grant and busy are registered. req_ready, fifo_wr_en and fifo_din are combinational from state plus inputs.

## Test plan
- **Single requester, BURST=4:** req_valid[0]=1 with data 0x10..0x15 and no last.
  - Writes 0x10..0x13 on cycles 1..4 after request.
  - 1 IDLE cycle, re-grant to 0, then 0x14, 0x15.
- **Round robin:** all four requesters valid continuously, each 2-beat bursts with last on beat 2.
  - Grant order 0,1,2,3,0.
  - fifo_wr_en pattern is 1,1,0 repeating.
- **Full stall:** grant to 1, fifo_full=1 for 3 cycles mid-burst after beat 2.
  - req_ready[1]=0 and fifo_wr_en=0 for those 3 cycles; grant stays on 1.
  - Beats 3–4 are written after full drops; release after beat 4.
- **Requester drop:** grant to 2; req_valid[2] falls after 1 beat.
  - Release next cycle, last_grant=2.
  - Next winner is 3 if valid, else 0.
- **Reset mid-burst:** rstn=0 for 1 cycle during beat 2 of requester 3.
  - That cycle: fifo_wr_en=0.
  - Next cycle: state IDLE, grant=0, busy=0.
  - Following arbitration starts from requester 0.
- **BURST=1, 3 requesters valid:**
  - Exactly one write per grant.
  - Order 0,1,2,0.
  - One write every 2 cycles.
